// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - GF(2^8) constants and elaboration-time helpers for the RS parity encoder
package rs_pkg;
  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] GF_POLY = 8'h5F;

  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} enc_state_t;

  function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] x);
    return {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? GF_POLY : '0);
  endfunction

  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] r;
    logic [SYM_W-1:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) r = r ^ t;
      t = gf_xtime(t);
    end
    return r;
  endfunction

  function automatic logic [SYM_W-1:0] gf_pow(input logic [SYM_W-1:0] alpha, input int j);
    logic [SYM_W-1:0] r;
    r = 8'h01;
    for (int i = 0; i < j; i++) r = gf_mul(r, alpha);
    return r;
  endfunction
endpackage

// File: rtl/gf_mult_const.sv
// rtl/gf_mult_const.sv - combinational GF(2^8) multiply by a constant coefficient
module gf_mult_const
  import rs_pkg::*;
#(
  parameter logic [SYM_W-1:0] COEF = 8'h01
) (
  input  logic [SYM_W-1:0] a,
  output logic [SYM_W-1:0] y
);
  // COEF is constant, so this folds into a fixed XOR network
  assign y = gf_mul(a, COEF);
endmodule

// File: rtl/rs_stream_encoder.sv
// rtl/rs_stream_encoder.sv - streaming two-parity RS encoder: accumulates K symbols, emits data+P0+P1
module rs_stream_encoder
  import rs_pkg::*;
#(
  parameter int K   = 8,
  parameter int SPB = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SPB*SYM_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(K+2)*SYM_W-1:0] out_codeword
);
  localparam int BEATS = K / SPB;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = SPB * SYM_W;
  localparam int CW    = K * SYM_W;

  enc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [SYM_W-1:0] p0_acc, p1_acc, p0_next, p1_next;
  logic [CW-1:0]    data_next;
  logic [SYM_W-1:0] prod [BEATS][SPB];
  logic             accept, last_beat;

  assign in_ready  = (state == ST_ACC) || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  // one constant multiplier per symbol slot; the beat counter picks which row applies
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    for (genvar p = 0; p < SPB; p++) begin : g_pos
      gf_mult_const #(.COEF(gf_pow(8'h02, b * SPB + p))) u_mul (
        .a (in_data[(SPB-1-p)*SYM_W +: SYM_W]),
        .y (prod[b][p])
      );
    end
  end

  always_comb begin
    p0_next = p0_acc;
    p1_next = p1_acc;
    for (int p = 0; p < SPB; p++) p0_next = p0_next ^ in_data[(SPB-1-p)*SYM_W +: SYM_W];
    for (int b = 0; b < BEATS; b++) begin
      if (cnt == CNT_W'(b)) begin
        for (int p = 0; p < SPB; p++) p1_next = p1_next ^ prod[b][p];
      end
    end
  end

  if (BEATS > 1) begin : g_buf
    logic [CW-DW-1:0] data_buf;
    // earlier beats shift toward the MSBs so symbol 0 lands on top
    assign data_next = {data_buf, in_data};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_buf <= '0;
      else if (accept) data_buf <= data_next[CW-DW-1:0];
    end
  end else begin : g_nobuf
    assign data_next = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ACC;
      cnt          <= '0;
      p0_acc       <= '0;
      p1_acc       <= '0;
      out_valid    <= 1'b0;
      out_codeword <= '0;
    end else begin
      if (out_valid && out_ready) begin
        state     <= ST_ACC;
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (last_beat) begin
          state        <= ST_HOLD;
          out_valid    <= 1'b1;
          out_codeword <= {data_next, p0_next, p1_next};
          cnt          <= '0;
          p0_acc       <= '0;
          p1_acc       <= '0;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          p0_acc <= p0_next;
          p1_acc <= p1_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_stream_encoder.sv
// tb/tb_rs_stream_encoder.sv - self-checking bench for rs_stream_encoder (K=8/SPB=8 and K=16/SPB=4)
module tb_rs_stream_encoder;
  logic         clk;
  logic         a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0]  a_in_data;
  logic [79:0]  a_cw;
  logic         b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0]  b_in_data;
  logic [143:0] b_cw;
  int           checks;
  int           failures;

  rs_stream_encoder #(.K(8), .SPB(8)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_codeword(a_cw)
  );

  rs_stream_encoder #(.K(16), .SPB(4)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_codeword(b_cw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference GF multiply by polynomial long division modulo 0x15F
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] pr;
    pr = '0;
    for (int i = 0; i < 8; i++) if (b[i]) pr = pr ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (pr[i]) pr = pr ^ (16'h015F << (i - 8));
    return pr[7:0];
  endfunction

  function automatic logic [15:0] ref_par(input logic [7:0] s [16], input int k);
    logic [7:0] p0, p1, al;
    p0 = '0; p1 = '0; al = 8'h01;
    for (int j = 0; j < k; j++) begin
      p0 = p0 ^ s[j];
      p1 = p1 ^ tb_mul(s[j], al);
      al = tb_mul(al, 8'h02);
    end
    return {p0, p1};
  endfunction

  task automatic b_beat(input logic [31:0] d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic regress_a(input int n);
    logic [79:0] q [$];
    logic [7:0]  s [16];
    int got, sent, cyc;
    got = 0; sent = 0; cyc = 0;
    for (int j = 0; j < 16; j++) s[j] = '0;
    while (got < n && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      a_in_valid  = (sent < n) && ($urandom_range(3) != 0);
      a_in_data   = {$urandom, $urandom};
      a_out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) check("ra_extra", 1, 0);
        else begin
          check("ra_cw", a_cw, q.pop_front());
          got++;
        end
      end
      if (a_in_valid && a_in_ready) begin
        for (int j = 0; j < 8; j++) s[j] = a_in_data[63-8*j -: 8];
        q.push_back({a_in_data, ref_par(s, 8)});
        sent++;
      end
    end
    a_in_valid = 1'b0;
    check("ra_count", got, n);
    check("ra_left", q.size(), 0);
  endtask

  task automatic regress_b(input int n);
    logic [143:0] q [$];
    logic [7:0]   s [16];
    logic [127:0] wbuf;
    int got, sent, cyc, bi;
    got = 0; sent = 0; cyc = 0; bi = 0; wbuf = '0;
    for (int j = 0; j < 16; j++) s[j] = '0;
    while (got < n && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      b_in_valid  = (sent < n) && ($urandom_range(3) != 0);
      b_in_data   = $urandom;
      b_out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (b_out_valid && b_out_ready) begin
        if (q.size() == 0) check("rb_extra", 1, 0);
        else begin
          check("rb_cw", b_cw, q.pop_front());
          got++;
        end
      end
      if (b_in_valid && b_in_ready) begin
        for (int p = 0; p < 4; p++) s[bi*4+p] = b_in_data[31-8*p -: 8];
        wbuf = {wbuf[95:0], b_in_data};
        if (bi == 3) begin
          q.push_back({wbuf, ref_par(s, 16)});
          sent++;
          bi = 0;
        end else bi++;
      end
    end
    b_in_valid = 1'b0;
    check("rb_count", got, n);
    check("rb_left", q.size(), 0);
  endtask

  initial begin
    logic [79:0] hold;
    checks = 0; failures = 0;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #3;
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_cw", a_cw, 0);
    check("rst_a_ready", a_in_ready, 1);
    check("rst_b_ready", b_in_ready, 1);
    repeat (2) @(posedge clk);
    #1 a_rst_n = 1'b1; b_rst_n = 1'b1;
    check("rel_a_ready", a_in_ready, 1);

    // single-beat words, then backpressure and back-to-back output
    a_in_valid = 1'b1; a_in_data = 64'h0100_0000_0000_0000;
    #1 check("t1_pre_valid", a_out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid", a_out_valid, 1);
    check("t1_cw", a_cw, {64'h0100_0000_0000_0000, 8'h01, 8'h01});
    check("t1_ready", a_in_ready, 0);
    hold = a_cw;
    a_in_data = 64'h0080_0000_0000_0000;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_cw", a_cw, hold);
      check("bp_valid", a_out_valid, 1);
      check("bp_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    #1 check("bp_pass_ready", a_in_ready, 1);
    @(posedge clk); #1;
    check("t2_valid", a_out_valid, 1);
    check("t2_cw", a_cw, {64'h0080_0000_0000_0000, 8'h80, 8'h5F});
    a_in_data = 64'h0000_0000_0000_0001;
    @(posedge clk); #1;
    check("t3_valid", a_out_valid, 1);
    check("t3_cw", a_cw, {64'h0000_0000_0000_0001, 8'h01, 8'h80});
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_valid", a_out_valid, 0);

    // four-beat word with only symbol 9 set
    b_out_ready = 1'b1;
    b_beat(32'h0);
    b_beat(32'h0);
    b_beat(32'h0001_0000);
    check("b9_pre_valid", b_out_valid, 0);
    b_beat(32'h0);
    check("b9_valid", b_out_valid, 1);
    check("b9_cw", b_cw, {32'h0, 32'h0, 32'h0001_0000, 32'h0, 8'h01, 8'hBE});
    @(posedge clk); #1;
    check("b9_clear", b_out_valid, 0);

    // reset after two beats discards the partial word
    b_beat(32'hFFFF_FFFF);
    b_beat(32'h1234_5678);
    b_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", b_out_valid, 0);
    check("mid_rst_cw", b_cw, 0);
    check("mid_rst_ready", b_in_ready, 1);
    @(posedge clk); #1 b_rst_n = 1'b1;
    b_beat(32'h0000_0001);
    b_beat(32'h0);
    b_beat(32'h0);
    b_beat(32'h0);
    check("post_rst_valid", b_out_valid, 1);
    check("post_rst_cw", b_cw, {32'h0000_0001, 96'h0, 8'h01, 8'h08});

    regress_a(10000);
    regress_b(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_stream_encoder.md
RS_STREAM_ENCODER -- requirements
Module: rs_stream_encoder

Interface
REQ-001 SHALL have parameter K, default 8: number of 8-bit data symbols per codeword; legal range 2..253.
REQ-002 SHALL have parameter SPB, default 8: symbols per input beat; K mod SPB = 0; BEATS = K/SPB.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a beat.
REQ-007 SHALL have port in_data, input, SPB*8: data symbols; the most significant byte is the lowest-index symbol of the beat.
REQ-008 SHALL have port out_valid, output, 1: the codeword is valid.
REQ-009 SHALL have port out_ready, input, 1: the sink accepts the codeword.
REQ-010 SHALL have port out_codeword, output, (K+2)*8: codeword as data symbols 0..K-1 (MSB first), then P0, then P1 (P1 in the LSBs).

Function
REQ-011 SHALL use GF(2^8) arithmetic with primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1 (0x15F), alpha = 0x02.
REQ-012 SHALL compute P0 = XOR of all d_j and P1 = XOR of (d_j * alpha^j), j = 0..K-1; symbol j is beat j/SPB, position j mod SPB.
REQ-013 SHALL be systematic: the data field of out_codeword equals the accepted beats concatenated in arrival order.
REQ-014 SHALL implement a 2-state FSM.
- ACC: accumulating beats.
- HOLD: codeword registered and out_valid = 1.
REQ-015 SHALL assert in_ready = 1 in ACC; in HOLD, in_ready SHALL equal out_ready (combinational pass-through).
REQ-016 SHALL accept a beat only when in_valid && in_ready.
- Each accepted beat increments the beat counter (0..BEATS-1) and updates the P0/P1 accumulators and the data buffer.
REQ-017 SHALL, on accepting beat BEATS-1, load out_codeword with the complete data and final parity, go to HOLD, and return the counter and accumulators to zero in the same edge.
REQ-018 SHALL have latency of one cycle: out_valid rises on the edge that accepts the last beat.
REQ-019 SHALL hold out_codeword and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL, on out_valid && out_ready with no last beat accepted, clear out_valid and go to ACC.
REQ-021 SHALL, on simultaneous output handshake and accepted non-last beat, go to ACC with the counter at 1.
REQ-022 SHALL, on simultaneous output handshake and accepted last beat (possible only when BEATS = 1), stay in HOLD with the new codeword; this sustains one codeword per cycle.
REQ-023 SHALL ignore in_data while in_valid = 0; counter and accumulators are unchanged.
REQ-024 SHALL use a constant coefficient alpha^j for each symbol, computed at elaboration time; there are no runtime multipliers by variable operands.

Reset
REQ-025 SHALL, while rst_n = 0, asynchronously force:
- state = ACC, beat counter = 0, P0/P1 accumulators = 0;
- out_valid = 0, out_codeword = 0.
REQ-026 SHALL discard a partially received codeword on reset mid-operation; the first beat after release is symbol group 0.
REQ-027 SHALL drive in_ready = 1 during and immediately after reset.

Structure
REQ-028 SHALL place SYM_W = 8, GF_POLY = 8'h5F (low byte of 0x15F) and a constant-function gf_pow(alpha, j) in a shared package rs_pkg.
REQ-029 SHALL use one sub-module, gf_mult_const: a combinational GF(2^8) multiply by a parameter constant, instantiated SPB times per beat position.
- The per-beat coefficient alpha^(beat*SPB + position) SHALL be selected from a constant table indexed by the beat counter.

Verification
REQ-030 SHALL cover K=8, SPB=8: in_data 64'h0100000000000000 -> out_codeword P0 = 8'h01, P1 = 8'h01; out_valid one cycle after the handshake.
REQ-031 SHALL cover K=8, SPB=8: in_data 64'h0080000000000000 (d1 = 0x80) -> P0 = 8'h80, P1 = 8'h5F (alpha^8).
REQ-032 SHALL cover K=16, SPB=4: four beats, only symbol 9 = 0x01 -> P0 = 8'h01, P1 = 8'hBE (alpha^9); the data field matches the input.
REQ-033 SHALL cover backpressure: out_ready held 0 for 5 cycles.
- out_codeword stays stable; in_ready = 0.
- Raising out_ready with in_valid = 1 (BEATS = 1) completes back-to-back words, one per cycle.
REQ-034 SHALL cover reset mid-operation: K=16, SPB=4, rst_n pulsed low after 2 beats.
- out_valid = 0 and out_codeword = 0 immediately.
- Four new beats then produce the parity of the new data only.
REQ-035 SHALL cover a random regression: 10k words, random in_valid/out_ready stalls; every output is checked against a reference model (P0/P1 per REQ-012) with no loss or duplication.
